fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- logic_width_p, 100, framebuffer columns
- logic_height_p, 72, framebuffer rows
- bit_depth_p, 1, bits per colour channel
- AW = $clog2(logic_width_p*logic_height_p), derived address width
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  single clock; all logic in this domain
- reset_i  in  1  asynchronous, active-low reset
- disp_v_i  in  1  display read request, every active-video cycle
- disp_x_i  in  $clog2(logic_width_p)  display column
- disp_y_i  in  $clog2(logic_height_p)  display row
- disp_valid_o  out  1  display read data valid
- disp_rgb_o  out  3*bit_depth_p  display pixel {r,g,b}
- wr_v_i  in  1  write request valid
- wr_ready_o  out  1  write request accepted when high with wr_v_i
- wr_x_i  in  $clog2(logic_width_p)  write column
- wr_y_i  in  $clog2(logic_height_p)  write row
- wr_rgb_i  in  3*bit_depth_p  write pixel
- clear_i  in  1  single-cycle pulse: fill framebuffer with clear_rgb_i
- clear_rgb_i  in  3*bit_depth_p  fill colour, sampled with clear_i
- clear_busy_o  out  1  clear in progress
- mem_addr_o  out  AW  single-port RAM address
- mem_we_o  out  1  RAM write enable
- mem_wdata_o  out  3*bit_depth_p  RAM write data
- mem_rdata_i  in  3*bit_depth_p  RAM read data, valid one cycle after address

Function
REQ-003 The address SHALL be y*logic_width_p + x, computed at AW bits without truncation.
REQ-004 The display SHALL have absolute priority: when disp_v_i=1, mem_addr_o SHALL be the display address and mem_we_o SHALL be 0 in that cycle.
REQ-005 Display latency SHALL be 2 cycles: a request in cycle N gives disp_valid_o=1 in cycle N+2, with disp_rgb_o = mem_rdata_i registered at the end of cycle N+1.
REQ-006 disp_rgb_o SHALL hold its last value while disp_valid_o=0.
REQ-007 A one-entry write buffer SHALL hold accepted writes; wr_ready_o = buffer empty AND state=IDLE.
REQ-008 The buffered write SHALL drain (mem_we_o=1, buffered address and data) in the first cycle with disp_v_i=0; the buffer becomes empty, and wr_ready_o is high, in the following cycle.
REQ-009 A write with wr_x_i>=logic_width_p or wr_y_i>=logic_height_p SHALL be accepted and discarded, with no mem_we_o pulse.
REQ-010 The FSM SHALL have states IDLE, DRAIN and CLEAR.
- IDLE: normal operation.
- clear_i in IDLE with the buffer full: go to DRAIN.
- clear_i in IDLE with the buffer empty: go to CLEAR.
- DRAIN: go to CLEAR after the buffered write is performed.
- CLEAR: go to IDLE after the write to the last address.
REQ-011 In CLEAR, a counter SHALL start at 0 and write clear_rgb (latched when clear_i is sampled) on every cycle with disp_v_i=0; it increments only on a performed write.
REQ-012 CLEAR SHALL end after address logic_width_p*logic_height_p-1 is written; the counter SHALL NOT wrap.
REQ-013 clear_busy_o SHALL be 1 in DRAIN and CLEAR and 0 in IDLE.
REQ-014 clear_i SHALL be ignored outside IDLE.
REQ-015 When clear_i and a wr_v_i handshake occur in the same IDLE cycle, the write SHALL be accepted, and the FSM SHALL go to DRAIN.
REQ-016 When no access is made, mem_addr_o SHALL hold its previous value and mem_we_o SHALL be 0.

Reset
REQ-017 While reset_i=0, the block SHALL force:
- state IDLE, buffer empty, clear counter 0
- disp_valid_o=0, disp_rgb_o=0
- mem_we_o=0, mem_addr_o=0, mem_wdata_o=0
- clear_busy_o=0
- wr_ready_o=0
REQ-018 Reset asserted mid-CLEAR SHALL abandon the fill. After release, the state SHALL be IDLE and wr_ready_o=1 on the first clock edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Display read x=3,y=2, RAM preloaded 3'b101 at address 203 -> mem_addr_o=203 in cycle N; disp_valid_o=1 and disp_rgb_o=3'b101 in cycle N+2.
- Write x=99,y=71,rgb=3'b010 with disp_v_i held 1 for 10 cycles -> no mem_we_o and wr_ready_o=0 for those cycles; on disp_v_i=0, mem_we_o=1, mem_addr_o=7199, mem_wdata_o=3'b010.
- Write x=100,y=0 -> handshake completes; mem_we_o never asserted.
- clear_i with rgb=3'b111, disp_v_i=0 throughout -> exactly 7200 writes covering addresses 0..7199; clear_busy_o high for 7200 cycles.
- clear_i in the same cycle as a write to address 5 -> the address-5 write occurs first, then CLEAR; clear_busy_o high from the next cycle.
- reset_i=0 after 100 clear writes -> all outputs at their reset values; after release, wr_ready_o=1 and clear_busy_o=0.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter
// Arbitrates one single-port framebuffer RAM between three users:
//   - the display scan-out, which has absolute priority and a fixed
//     two-cycle read latency,
//   - a pixel write port backed by a one-entry write buffer,
//   - a full-screen clear engine that fills every pixel with one colour.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-low reset
//   disp_v_i/x_i/y_i        display read request (column, row)
//   disp_valid_o/rgb_o      display read result, two cycles after request
//   wr_v_i/ready_o          write handshake
//   wr_x_i/y_i/rgb_i        write pixel position and colour
//   clear_i, clear_rgb_i    one-cycle clear request and fill colour
//   clear_busy_o            clear (including the pre-clear drain) running
//   mem_addr_o/we_o/wdata_o single-port RAM request
//   mem_rdata_i             RAM read data, one cycle after the address
module fb_arbiter #(
  parameter int logic_width_p  = 100,
  parameter int logic_height_p = 72,
  parameter int bit_depth_p    = 1,
  parameter int AW             = $clog2(logic_width_p * logic_height_p),
  localparam int XW = (logic_width_p  > 1) ? $clog2(logic_width_p)  : 1,
  localparam int YW = (logic_height_p > 1) ? $clog2(logic_height_p) : 1,
  localparam int CW = 3 * bit_depth_p
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          disp_v_i,
  input  logic [XW-1:0] disp_x_i,
  input  logic [YW-1:0] disp_y_i,
  output logic          disp_valid_o,
  output logic [CW-1:0] disp_rgb_o,
  input  logic          wr_v_i,
  output logic          wr_ready_o,
  input  logic [XW-1:0] wr_x_i,
  input  logic [YW-1:0] wr_y_i,
  input  logic [CW-1:0] wr_rgb_i,
  input  logic          clear_i,
  input  logic [CW-1:0] clear_rgb_i,
  output logic          clear_busy_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [CW-1:0] mem_wdata_o,
  input  logic [CW-1:0] mem_rdata_i
);

  localparam int unsigned   PIXELS     = logic_width_p * logic_height_p;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(PIXELS - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(logic_width_p);
  localparam logic [XW:0]   X_LIMIT    = (XW + 1)'(logic_width_p);
  localparam logic [YW:0]   Y_LIMIT    = (YW + 1)'(logic_height_p);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t        state;
  logic          clear_busy_q;
  logic          buf_full;
  logic [AW-1:0] buf_addr;
  logic [CW-1:0] buf_rgb;
  logic [AW-1:0] clr_cnt;
  logic [CW-1:0] clr_rgb;
  logic [AW-1:0] last_addr;
  logic          disp_v_d1;

  logic [AW-1:0] disp_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_in_range;
  logic          ready_int;
  logic          wr_hs;
  logic          drain_go;
  logic          clear_go;
  logic [AW-1:0] acc_addr;
  logic          acc_we;
  logic [CW-1:0] acc_wdata;

  // Coordinates are widened to AW bits before the multiply so the linear
  // address never truncates.
  assign disp_addr   = AW'(disp_y_i) * ROW_STRIDE + AW'(disp_x_i);
  assign wr_addr     = AW'(wr_y_i) * ROW_STRIDE + AW'(wr_x_i);
  assign wr_in_range = ({1'b0, wr_x_i} < X_LIMIT) && ({1'b0, wr_y_i} < Y_LIMIT);

  // The buffer is only ever full in IDLE or DRAIN, so draining needs no
  // state qualifier; the clear engine uses the RAM only when the display
  // leaves it free.
  assign ready_int = !buf_full && (state == IDLE);
  assign wr_hs     = wr_v_i && ready_int;
  assign drain_go  = buf_full && !disp_v_i;
  assign clear_go  = (state == CLEAR) && !disp_v_i;

  // RAM port mux: display first, then buffered write, then clear fill.
  // With no access the address holds its last value.
  always_comb begin
    acc_addr  = last_addr;
    acc_we    = 1'b0;
    acc_wdata = buf_rgb;
    if (disp_v_i) begin
      acc_addr = disp_addr;
    end else if (drain_go) begin
      acc_addr  = buf_addr;
      acc_we    = 1'b1;
      acc_wdata = buf_rgb;
    end else if (clear_go) begin
      acc_addr  = clr_cnt;
      acc_we    = 1'b1;
      acc_wdata = clr_rgb;
    end
  end

  // Outputs are forced to zero while reset is held; the internal versions
  // stay reset-free so no flop data path depends on the reset net.
  assign mem_addr_o   = reset_i ? acc_addr  : '0;
  assign mem_wdata_o  = reset_i ? acc_wdata : '0;
  assign mem_we_o     = reset_i && acc_we;
  assign wr_ready_o   = reset_i && ready_int;
  assign clear_busy_o = clear_busy_q;

  // Remembers the address of the last real access for idle cycles.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      last_addr <= '0;
    end else if (disp_v_i || acc_we) begin
      last_addr <= acc_addr;
    end
  end

  // Display return path: the RAM answers one cycle after the address and
  // that answer is registered once more, giving the two-cycle latency.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      disp_v_d1    <= 1'b0;
      disp_valid_o <= 1'b0;
      disp_rgb_o   <= '0;
    end else begin
      disp_v_d1    <= disp_v_i;
      disp_valid_o <= disp_v_d1;
      if (disp_v_d1) begin
        disp_rgb_o <= mem_rdata_i;
      end
    end
  end

  // Control FSM with the write buffer and clear counter. A clear must not
  // overtake a write the user already saw accepted, so a pending (or
  // simultaneously accepted) write sends the FSM through DRAIN first.
  // Out-of-range writes complete the handshake but never fill the buffer.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= IDLE;
      clear_busy_q <= 1'b0;
      buf_full     <= 1'b0;
      buf_addr     <= '0;
      buf_rgb      <= '0;
      clr_cnt      <= '0;
      clr_rgb      <= '0;
    end else begin
      if (drain_go) begin
        buf_full <= 1'b0;
      end
      if (wr_hs && wr_in_range) begin
        buf_full <= 1'b1;
        buf_addr <= wr_addr;
        buf_rgb  <= wr_rgb_i;
      end

      case (state)
        IDLE: begin
          if (clear_i) begin
            clr_rgb      <= clear_rgb_i;
            clr_cnt      <= '0;
            clear_busy_q <= 1'b1;
            if ((buf_full && !drain_go) || wr_hs) begin
              state <= DRAIN;
            end else begin
              state <= CLEAR;
            end
          end
        end
        DRAIN: begin
          if (!buf_full || drain_go) begin
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (clear_go) begin
            if (clr_cnt == LAST_ADDR) begin
              state        <= IDLE;
              clr_cnt      <= '0;
              clear_busy_q <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + AW'(1);
            end
          end
        end
        default: begin
          state        <= IDLE;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter
// Drives fb_arbiter with directed scenarios and random traffic and compares
// every cycle against a transaction-level model: a one-slot pending write,
// a clear described by (colour, next index, writes left), and an expected
// image of the framebuffer. A behavioural RAM supplies read data.
module tb_fb_arbiter;

  localparam int W   = 100;
  localparam int H   = 72;
  localparam int PIX = W * H;
  localparam int AW  = 13;
  localparam int XW  = 7;
  localparam int YW  = 7;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          disp_v_i = 1'b0;
  logic [XW-1:0] disp_x_i = '0;
  logic [YW-1:0] disp_y_i = '0;
  logic          disp_valid_o;
  logic [2:0]    disp_rgb_o;
  logic          wr_v_i = 1'b0;
  logic          wr_ready_o;
  logic [XW-1:0] wr_x_i = '0;
  logic [YW-1:0] wr_y_i = '0;
  logic [2:0]    wr_rgb_i = '0;
  logic          clear_i = 1'b0;
  logic [2:0]    clear_rgb_i = '0;
  logic          clear_busy_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [2:0]    mem_wdata_o;
  logic [2:0]    mem_rdata_i;

  fb_arbiter dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .disp_v_i     (disp_v_i),
    .disp_x_i     (disp_x_i),
    .disp_y_i     (disp_y_i),
    .disp_valid_o (disp_valid_o),
    .disp_rgb_o   (disp_rgb_o),
    .wr_v_i       (wr_v_i),
    .wr_ready_o   (wr_ready_o),
    .wr_x_i       (wr_x_i),
    .wr_y_i       (wr_y_i),
    .wr_rgb_i     (wr_rgb_i),
    .clear_i      (clear_i),
    .clear_rgb_i  (clear_rgb_i),
    .clear_busy_o (clear_busy_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port RAM, zero-filled with pixel 203 preloaded.
  logic [2:0] ram [0:PIX-1];
  bit         ram_ready = 1'b0;
  always @(posedge clk_i) begin
    if (!ram_ready) begin
      for (int i = 0; i < PIX; i++) ram[i] <= 3'b000;
      ram[203]  <= 3'b101;
      ram_ready <= 1'b1;
    end else if (mem_we_o && int'(mem_addr_o) < PIX) begin
      ram[mem_addr_o] <= mem_wdata_o;
    end
    mem_rdata_i <= (int'(mem_addr_o) < PIX) ? ram[mem_addr_o] : 3'b000;
  end

  int vectors = 0;
  int miscompares = 0;
  int now = 0;

  // Model state
  logic [2:0] ref_fb [0:PIX-1];
  logic       m_buf_valid = 1'b0;
  int         m_buf_addr = 0;
  logic [2:0] m_buf_rgb = 3'b000;
  int         m_buf_cycle = 0;
  int         m_clr_left = 0;
  int         m_clr_idx = 0;
  logic [2:0] m_clr_rgb = 3'b000;
  int         m_clr_cycle = 0;
  logic       d1 = 1'b0, d2 = 1'b0;
  logic [2:0] p1 = 3'b000, p2 = 3'b000, exp_rgb = 3'b000;
  int         exp_last_addr = 0;

  // Observation counters for the full-clear scenario
  int obs_writes = 0, obs_busy = 0, obs_distinct = 0;
  bit written [0:PIX-1];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
               tag, actual, expected, now);
    end
  endtask

  // Called at the falling edge: compare this cycle, then advance the model.
  task automatic checkCycle();
    int d_addr, e_addr;
    logic [2:0] e_data;
    logic e_we, e_busy, e_ready, pop_buf, pop_clr;
    d_addr = int'(disp_y_i) * W + int'(disp_x_i);
    if (mem_we_o === 1'b1 && int'(mem_addr_o) < PIX) begin
      obs_writes++;
      if (!written[mem_addr_o]) begin
        written[mem_addr_o] = 1'b1;
        obs_distinct++;
      end
    end
    if (clear_busy_o === 1'b1) obs_busy++;

    if (reset_i === 1'b0) begin
      checkOutput("rst_disp_valid", 32'(disp_valid_o), 32'd0);
      checkOutput("rst_disp_rgb",   32'(disp_rgb_o),   32'd0);
      checkOutput("rst_mem_we",     32'(mem_we_o),     32'd0);
      checkOutput("rst_mem_addr",   32'(mem_addr_o),   32'd0);
      checkOutput("rst_mem_wdata",  32'(mem_wdata_o),  32'd0);
      checkOutput("rst_clear_busy", 32'(clear_busy_o), 32'd0);
      checkOutput("rst_wr_ready",   32'(wr_ready_o),   32'd0);
      m_buf_valid = 1'b0; m_clr_left = 0; m_clr_idx = 0;
      d1 = 1'b0; d2 = 1'b0; exp_rgb = 3'b000; exp_last_addr = 0;
      now++;
      return;
    end

    e_busy  = (m_clr_left > 0);
    e_ready = !m_buf_valid && !e_busy;
    e_we = 1'b0; e_addr = exp_last_addr; e_data = 3'b000;
    pop_buf = 1'b0; pop_clr = 1'b0;
    if (disp_v_i) begin
      e_addr = d_addr;
    end else if (m_buf_valid && m_buf_cycle < now) begin
      e_we = 1'b1; e_addr = m_buf_addr; e_data = m_buf_rgb; pop_buf = 1'b1;
    end else if (!m_buf_valid && m_clr_left > 0 && m_clr_cycle < now) begin
      e_we = 1'b1; e_addr = m_clr_idx; e_data = m_clr_rgb; pop_clr = 1'b1;
    end
    if (d2) exp_rgb = p2;

    checkOutput("wr_ready",   32'(wr_ready_o),   32'(e_ready));
    checkOutput("clear_busy", 32'(clear_busy_o), 32'(e_busy));
    checkOutput("mem_we",     32'(mem_we_o),     32'(e_we));
    checkOutput("mem_addr",   32'(mem_addr_o),   32'(e_addr));
    if (e_we) checkOutput("mem_wdata", 32'(mem_wdata_o), 32'(e_data));
    checkOutput("disp_valid", 32'(disp_valid_o), 32'(d2));
    checkOutput("disp_rgb",   32'(disp_rgb_o),   32'(exp_rgb));

    if (e_we) ref_fb[e_addr] = e_data;
    if (disp_v_i || e_we) exp_last_addr = e_addr;
    if (pop_buf) m_buf_valid = 1'b0;
    if (pop_clr) begin
      m_clr_idx++;
      m_clr_left--;
    end
    if (wr_v_i && e_ready && int'(wr_x_i) < W && int'(wr_y_i) < H) begin
      m_buf_valid = 1'b1;
      m_buf_addr  = int'(wr_y_i) * W + int'(wr_x_i);
      m_buf_rgb   = wr_rgb_i;
      m_buf_cycle = now;
    end
    if (clear_i && !e_busy) begin
      m_clr_left  = PIX;
      m_clr_idx   = 0;
      m_clr_rgb   = clear_rgb_i;
      m_clr_cycle = now;
    end
    d2 = d1; p2 = p1;
    d1 = disp_v_i;
    if (disp_v_i) p1 = ref_fb[d_addr];
    now++;
  endtask

  task automatic applyStimulus(input logic rst_v, input logic dv, input int dx,
                               input int dy, input logic wv, input int wx,
                               input int wy, input logic [2:0] wrgb,
                               input logic clr, input logic [2:0] crgb);
    @(posedge clk_i);
    #1;
    reset_i     = rst_v;
    disp_v_i    = dv;
    disp_x_i    = XW'(dx);
    disp_y_i    = YW'(dy);
    wr_v_i      = wv;
    wr_x_i      = XW'(wx);
    wr_y_i      = YW'(wy);
    wr_rgb_i    = wrgb;
    clear_i     = clr;
    clear_rgb_i = crgb;
    @(negedge clk_i);
    checkCycle();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 3'b000, 1'b0, 3'b000);
  endtask

  task automatic clearObservations();
    obs_writes = 0; obs_busy = 0; obs_distinct = 0;
    for (int i = 0; i < PIX; i++) written[i] = 1'b0;
  endtask

  initial begin
    int guard;
    int errs;
    bit rand_clear_done;
    for (int i = 0; i < PIX; i++) ref_fb[i] = 3'b000;
    ref_fb[203] = 3'b101;
    rand_clear_done = 1'b0;

    // Reset with a display request present: address must still be forced 0
    repeat (3) applyStimulus(1'b0, 1'b1, 3, 2, 1'b0, 0, 0, 3'b000, 1'b0, 3'b000);
    idleCycles(3);

    // Display read of (3,2) -> address 203, data 3'b101 two cycles later
    applyStimulus(1'b1, 1'b1, 3, 2, 1'b0, 0, 0, 3'b000, 1'b0, 3'b000);
    idleCycles(3);

    // Write to the last pixel blocked by 10 display cycles, then drained
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b1, 99, 71, 3'b010, 1'b0, 3'b000);
    repeat (9) applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 0, 0, 3'b000, 1'b0, 3'b000);
    idleCycles(3);

    // Out-of-range write: accepted, never reaches the RAM
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 100, 0, 3'b111, 1'b0, 3'b000);
    idleCycles(3);

    // Full clear with an ignored second clear request part-way through
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 3'b000, 1'b1, 3'b111);
    clearObservations();
    guard = 0;
    while (m_clr_left > 0 && guard < 10000) begin
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 3'b000, guard == 1000, 3'b000);
      guard++;
    end
    checkOutput("clear_write_count", 32'(obs_writes), 32'(PIX));
    checkOutput("clear_distinct_addrs", 32'(obs_distinct), 32'(PIX));
    checkOutput("clear_busy_cycles", 32'(obs_busy), 32'(PIX));
    idleCycles(2);

    // Clear and a write to address 5 in the same cycle
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 5, 0, 3'b100, 1'b1, 3'b110);
    guard = 0;
    while (m_clr_left > 0 && guard < 10000) begin
      idleCycles(1);
      guard++;
    end
    checkOutput("clear_after_write_done", 32'(m_clr_left), 32'd0);
    idleCycles(2);

    // Reset after 100 clear writes abandons the fill
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 3'b000, 1'b1, 3'b011);
    guard = 0;
    while (m_clr_idx < 100 && guard < 1000) begin
      idleCycles(1);
      guard++;
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 3'b000, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 7, 7, 1'b0, 0, 0, 3'b000, 1'b0, 3'b000);
    idleCycles(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic dv, wv, clr;
      int dx, dy, wx, wy;
      logic [2:0] wrgb, crgb;
      dv   = ($urandom_range(0, 99) < 50);
      dx   = $urandom_range(0, W - 1);
      dy   = $urandom_range(0, H - 1);
      wv   = ($urandom_range(0, 1) == 1);
      wrgb = 3'($urandom_range(0, 7));
      crgb = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        wx = $urandom_range(0, 127);
        wy = $urandom_range(0, 127);
      end else begin
        wx = $urandom_range(0, W - 1);
        wy = $urandom_range(0, H - 1);
      end
      clr = ($urandom_range(0, 399) == 0) && (m_clr_left > 0 || !rand_clear_done);
      if (clr) begin
        dv = 1'b1;
        wx = wx % W;
        wy = wy % H;
        if (m_clr_left == 0) rand_clear_done = 1'b1;
      end
      applyStimulus(1'b1, dv, dx, dy, wv, wx, wy, wrgb, clr, crgb);
    end

    guard = 0;
    while ((m_clr_left > 0 || m_buf_valid) && guard < 20000) begin
      idleCycles(1);
      guard++;
    end
    checkOutput("quiesce_bound", 32'(guard < 20000), 32'd1);
    idleCycles(3);

    errs = 0;
    for (int a = 0; a < PIX; a++) if (ram[a] !== ref_fb[a]) errs++;
    checkOutput("final_image", 32'(errs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
